uart_rx_mmio: RTL and testbench

//  UART receiver peripheral on the IO MMIO bus; receive-side partner of the UART TX in the LED/UART block.

---
 rtl/uart_rx_mmio_if.sv | 23 ++
 rtl/uart_rx_mmio.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mmio_if.sv
// MMIO request/response bundle between the CPU IO bus and a peripheral.
// The master drives a request; the slave answers with a one-cycle ready pulse.
interface uart_rx_mmio_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;
    logic              ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver with an RX FIFO and sticky error flags, read by the CPU over MMIO.
// RX_DATA pops one byte per read; RX_STAT reports FIFO state and W1C error flags.
module uart_rx_mmio #(
    parameter int unsigned UART_DIV       = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned XLEN           = 32,
    parameter logic [31:0] IO_BASE_ADDR   = 32'h1000_0000,
    parameter logic [31:0] RX_DATA_OFFSET = 32'h20,
    parameter logic [31:0] RX_STAT_OFFSET = 32'h24
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_mmio_if.slave  mmio,
    input  logic           uart_rx,
    output logic           rx_irq
);
    localparam int unsigned CntW   = $clog2(UART_DIV);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    localparam logic [CntW-1:0]   HalfBit  = CntW'(UART_DIV / 2 - 1);
    localparam logic [CntW-1:0]   FullBit  = CntW'(UART_DIV - 1);
    localparam logic [ADDR_W-1:0] DataAddr = ADDR_W'(IO_BASE_ADDR + RX_DATA_OFFSET);
    localparam logic [ADDR_W-1:0] StatAddr = ADDR_W'(IO_BASE_ADDR + RX_STAT_OFFSET);
    localparam logic [CountW-1:0] FullCnt  = CountW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Two-flop synchronizer plus one delayed copy for edge detection
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic            rx_push, frame_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        rx_push   = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    state_d = StStart;
                    cnt_d   = HalfBit;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    // A start bit that is high again mid-bit was only a glitch
                    if (!rx_s_q) begin
                        state_d = StData;
                        cnt_d   = FullBit;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_s_q, sh_q[7:1]};
                    cnt_d = FullBit;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    rx_push   = rx_s_q;
                    frame_set = ~rx_s_q;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // MMIO: accept a request, answer it on the following edge
    logic              pending_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        wclr_q;
    logic              ready_q;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   rd_val;
    logic              accept, fire, hit_data, hit_stat;
    logic              pop, clr_ovr, clr_fe;
    logic              unused_wdata;

    assign unused_wdata = ^mmio.wdata;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic              full, empty, push_ok, overrun_set;
    logic              ovr_q, fe_q;

    assign accept   = mmio.req & ~pending_q;
    assign fire     = pending_q;
    assign hit_data = (addr_q == DataAddr);
    assign hit_stat = (addr_q == StatAddr);
    assign full     = (count_q == FullCnt);
    assign empty    = (count_q == '0);
    assign pop      = fire & ~we_q & hit_data & ~empty;
    assign clr_ovr  = fire & we_q & hit_stat & wclr_q[0];
    assign clr_fe   = fire & we_q & hit_stat & wclr_q[1];

    // A simultaneous pop frees the slot, so a push into a full FIFO is still legal
    assign push_ok     = rx_push & (~full | pop);
    assign overrun_set = rx_push & full & ~pop;

    always_comb begin
        rd_val = '0;
        if (!we_q) begin
            if (hit_data && !empty) begin
                rd_val[8]   = 1'b1;
                rd_val[7:0] = mem[rd_ptr_q];
            end else if (hit_stat) begin
                rd_val[0]    = ~empty;
                rd_val[1]    = full;
                rd_val[2]    = ovr_q;
                rd_val[3]    = fe_q;
                rd_val[15:8] = 8'(count_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wclr_q    <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ready_q <= fire;
            if (fire) begin
                rdata_q   <= rd_val;
                pending_q <= 1'b0;
            end
            if (accept) begin
                pending_q <= 1'b1;
                we_q      <= mmio.we;
                addr_q    <= mmio.addr;
                wclr_q    <= mmio.wdata[3:2];
            end
        end
    end

    assign mmio.ready = ready_q;
    assign mmio.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= sh_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CountW'(1);
            end
            // Set beats a same-cycle W1C clear
            ovr_q <= overrun_set | (ovr_q & ~clr_ovr);
            fe_q  <= frame_set | (fe_q & ~clr_fe);
        end
    end

    assign rx_irq = ~empty | ovr_q | fe_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial frames in, MMIO reads checked against a byte-queue model.
// The model tracks received bytes and sticky flags at frame/transaction granularity.
module tb_uart_rx_mmio;
    localparam int unsigned Div   = 16;
    localparam int unsigned Depth = 8;
    localparam logic [31:0] Base  = 32'h1000_0000;
    localparam logic [31:0] DataA = Base + 32'h20;
    localparam logic [31:0] StatA = Base + 32'h24;

    logic clk = 1'b0;
    logic rst;
    logic uart_rx;
    logic rx_irq;

    always #5 clk = ~clk;

    uart_rx_mmio_if #(.ADDR_W(32), .XLEN(32)) mmio ();

    uart_rx_mmio #(
        .UART_DIV       (Div),
        .FIFO_DEPTH     (Depth),
        .ADDR_W         (32),
        .XLEN           (32),
        .IO_BASE_ADDR   (Base),
        .RX_DATA_OFFSET (32'h20),
        .RX_STAT_OFFSET (32'h24)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mmio    (mmio.slave),
        .uart_rx (uart_rx),
        .rx_irq  (rx_irq)
    );

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [7:0]  mq[$];
    bit          m_ovr;
    bit          m_fe;
    bit          model_valid;
    bit          abort;
    int          exp_kind;   // 0 none, 1 read, 2 write
    logic [31:0] exp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_stat();
        logic [31:0] v;
        v       = '0;
        v[0]    = (mq.size() != 0);
        v[1]    = (mq.size() == Depth);
        v[2]    = m_ovr;
        v[3]    = m_fe;
        v[15:8] = 8'(mq.size());
        return v;
    endfunction

    function automatic logic model_irq();
        return (mq.size() != 0) || m_ovr || m_fe;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    // Per-cycle comparison of the interrupt level and every read response
    always @(negedge clk) begin
        if (!rst && model_valid) begin
            chk("rx_irq", 32'(rx_irq), 32'(model_irq()));
        end
        if (mmio.ready) begin
            if (exp_kind == 1) begin
                chk("rdata", mmio.rdata, exp_rdata);
            end else if (exp_kind == 0) begin
                chk("spurious_ready", 32'(mmio.ready), 32'd0);
            end
            exp_kind <= 0;
        end
    end

    task automatic wait_ready(input string name, output logic [31:0] d);
        int n = 0;
        while (!mmio.ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, 32'(mmio.ready), 32'd1);
        d = mmio.rdata;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        bit         mv;
        logic [7:0] b;
        @(negedge clk);
        mv          = model_valid;
        model_valid = 1'b0;
        if (a == DataA) begin
            if (mq.size() != 0) begin
                b         = mq.pop_front();
                exp_rdata = {23'b0, 1'b1, b};
            end else begin
                exp_rdata = 32'd0;
            end
        end else if (a == StatA) begin
            exp_rdata = model_stat();
        end else begin
            exp_rdata = 32'd0;
        end
        exp_kind   = 1;
        mmio.req   = 1'b1;
        mmio.we    = 1'b0;
        mmio.addr  = a;
        mmio.wdata = $urandom;
        @(negedge clk);
        mmio.req = 1'b0;
        wait_ready("read", d);
        model_valid = mv;
    endtask

    task automatic mmio_write(input logic [31:0] a, input logic [31:0] wd);
        bit          mv;
        logic [31:0] d;
        @(negedge clk);
        mv          = model_valid;
        model_valid = 1'b0;
        if (a == StatA) begin
            if (wd[2]) m_ovr = 1'b0;
            if (wd[3]) m_fe = 1'b0;
        end
        exp_kind   = 2;
        mmio.req   = 1'b1;
        mmio.we    = 1'b1;
        mmio.addr  = a;
        mmio.wdata = wd;
        @(negedge clk);
        mmio.req = 1'b0;
        mmio.we  = 1'b0;
        wait_ready("write", d);
        model_valid = mv;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        model_valid = 1'b0;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (Div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (Div) @(negedge clk);
        end
        uart_rx = stop;
        repeat (Div) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        if (!abort) begin
            if (stop) begin
                if (mq.size() < Depth) mq.push_back(b);
                else m_ovr = 1'b1;
            end else begin
                m_fe = 1'b1;
            end
        end
        model_valid = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        mmio.req    = 1'b0;
        mmio.we     = 1'b0;
        mmio.addr   = '0;
        mmio.wdata  = '0;
        uart_rx     = 1'b1;
        rst         = 1'b1;
        model_valid = 1'b0;
        abort       = 1'b0;
        exp_kind    = 0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(mmio.ready), 32'd0);
        chk("rst_irq", 32'(rx_irq), 32'd0);
        chk("rst_rdata", mmio.rdata, 32'd0);
        rst         = 1'b0;
        model_valid = 1'b1;
        mmio_read(StatA, d);            chk("t1_stat", d, 32'h0000_0000);
        mmio_read(DataA, d);            chk("t1_data", d, 32'h0000_0000);
        mmio_write(Base + 32'h28, 32'hFFFF_FFFF);
        mmio_read(Base + 32'h28, d);    chk("t1_unmapped", d, 32'h0000_0000);

        // Single byte
        send_frame(8'hA5, 1'b1);
        mmio_read(StatA, d);            chk("t2_stat", d, 32'h0000_0101);
        chk("t2_irq", 32'(rx_irq), 32'd1);
        mmio_read(DataA, d);            chk("t2_data", d, 32'h0000_01A5);
        mmio_read(StatA, d);            chk("t2_stat_empty", d, 32'h0000_0000);

        // Overflow: ninth byte is lost
        for (int i = 0; i <= Depth; i++) send_frame(8'(i), 1'b1);
        mmio_read(StatA, d);            chk("t3_stat_full", d, 32'h0000_0807);
        for (int i = 0; i < Depth; i++) begin
            mmio_read(DataA, d);        chk("t3_data", d, 32'h100 + 32'(i));
        end
        mmio_read(DataA, d);            chk("t3_data_empty", d, 32'h0000_0000);
        mmio_read(StatA, d);            chk("t3_stat_ovr", d, 32'h0000_0004);
        mmio_write(StatA, 32'h0000_0004);
        mmio_read(StatA, d);            chk("t3_stat_clr", d, 32'h0000_0000);

        // Framing error and W1C
        send_frame(8'h55, 1'b0);
        mmio_read(StatA, d);            chk("t4_stat_fe", d, 32'h0000_0008);
        mmio_write(StatA, 32'h0000_0008);
        mmio_read(StatA, d);            chk("t4_stat_clr", d, 32'h0000_0000);
        chk("t4_irq", 32'(rx_irq), 32'd0);

        // Short glitch is rejected, next frame still lands
        @(negedge clk);
        model_valid = 1'b0;
        uart_rx     = 1'b0;
        repeat (Div / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * Div) @(negedge clk);
        model_valid = 1'b1;
        mmio_read(StatA, d);            chk("t5_stat_glitch", d, 32'h0000_0000);
        send_frame(8'h3C, 1'b1);
        mmio_read(DataA, d);            chk("t5_data", d, 32'h0000_013C);

        // Pop lands on the very edge that pushes into a full FIFO
        for (int i = 0; i < Depth; i++) send_frame(8'h10 + 8'(i), 1'b1);
        mmio_read(StatA, d);            chk("t6_stat_full", d, 32'h0000_0803);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (153) @(negedge clk);
                mmio_read(DataA, d);
            end
        join
        chk("t6_pop_data", d, 32'h0000_0110);
        mmio_read(StatA, d);            chk("t6_stat_no_ovr", d, 32'h0000_0803);

        // Reset in the middle of a frame flushes everything
        abort = 1'b1;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (91) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_clear();
            end
        join
        abort = 1'b0;
        mmio_read(StatA, d);            chk("t6_stat_rst", d, 32'h0000_0000);
        chk("t6_irq_rst", 32'(rx_irq), 32'd0);
        send_frame(8'h5A, 1'b1);
        mmio_read(DataA, d);            chk("t6_data_after_rst", d, 32'h0000_015A);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
